// File: rtl/drac_pkg.sv
// Shared rename-stage types and sizes for the integer and FP free lists and rename tables.
package drac_pkg;

    localparam int unsigned NUM_ISA_REGISTERS         = 32;
    localparam int unsigned NUM_PHYSICAL_REGISTERS    = 64;
    localparam int unsigned NUM_FP_PHYSICAL_REGISTERS = 64;
    localparam int unsigned NUM_CHECKPOINTS           = 4;

    localparam int unsigned PHYSICAL_REGFILE_IDX = $clog2(NUM_PHYSICAL_REGISTERS);
    localparam int unsigned CHECKPOINT_IDX       = $clog2(NUM_CHECKPOINTS);
    localparam int unsigned NUM_CKPT_W           = CHECKPOINT_IDX + 1;

    // FP free list holds every physical register not mapped at reset
    localparam int unsigned FP_FL_DEPTH = NUM_FP_PHYSICAL_REGISTERS - NUM_ISA_REGISTERS;
    localparam int unsigned FP_FL_IDX   = $clog2(FP_FL_DEPTH);
    localparam int unsigned FL_PTR_W    = FP_FL_IDX + 1;

    typedef logic [PHYSICAL_REGFILE_IDX-1:0] phreg_t;
    typedef logic [CHECKPOINT_IDX-1:0]       checkpoint_ptr;
    typedef logic [NUM_CKPT_W-1:0]           num_ckpt_t;
    // Extra MSB separates a full list from an empty one
    typedef logic [FL_PTR_W-1:0]             fl_ptr_t;

endpackage

// File: rtl/free_list_checkpoint_ctrl.sv
// Checkpoint bookkeeping shared by the free lists: version pointers, occupancy and the
// checkpoint enable, kept bit-identical to the matching rename table.
module free_list_checkpoint_ctrl
    import drac_pkg::*;
(
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          do_checkpoint_i,
    input  logic          do_recover_i,
    input  logic          delete_checkpoint_i,
    input  checkpoint_ptr recover_checkpoint_i,
    input  logic          recover_commit_i,
    output logic          ckpt_en_c_o,
    output checkpoint_ptr ckpt_slot_c_o,
    output checkpoint_ptr checkpoint_o,
    output logic          out_of_checkpoints_o
);

    checkpoint_ptr version_head_q, version_head_d;
    checkpoint_ptr version_tail_q, version_tail_d;
    checkpoint_ptr checkpoint_d;
    num_ckpt_t     num_checkpoints_q, num_checkpoints_d;

    assign ckpt_en_c_o = do_checkpoint_i
                       & (num_checkpoints_q < num_ckpt_t'(NUM_CHECKPOINTS - 1))
                       & ~do_recover_i & ~recover_commit_i;
    assign ckpt_slot_c_o        = version_head_q + checkpoint_ptr'(1);
    assign out_of_checkpoints_o = (num_checkpoints_q == num_ckpt_t'(NUM_CHECKPOINTS - 1));

    always_comb begin
        version_head_d    = version_head_q;
        version_tail_d    = version_tail_q;
        num_checkpoints_d = num_checkpoints_q;
        checkpoint_d      = version_head_q;
        if (recover_commit_i) begin
            version_head_d    = '0;
            version_tail_d    = '0;
            num_checkpoints_d = '0;
            checkpoint_d      = '0;
        end else begin
            version_tail_d = version_tail_q + checkpoint_ptr'(delete_checkpoint_i);
            if (do_recover_i) begin
                // Live checkpoints are those between the oldest and the restored label
                version_head_d = recover_checkpoint_i;
                if (recover_checkpoint_i >= version_tail_q) begin
                    num_checkpoints_d = num_ckpt_t'(recover_checkpoint_i)
                                      - num_ckpt_t'(version_tail_q);
                end else begin
                    num_checkpoints_d = num_ckpt_t'(NUM_CHECKPOINTS)
                                      - num_ckpt_t'(version_tail_q)
                                      + num_ckpt_t'(recover_checkpoint_i);
                end
            end else begin
                version_head_d    = version_head_q + checkpoint_ptr'(ckpt_en_c_o);
                num_checkpoints_d = num_checkpoints_q + num_ckpt_t'(ckpt_en_c_o)
                                  - num_ckpt_t'(delete_checkpoint_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            version_head_q    <= '0;
            version_tail_q    <= '0;
            num_checkpoints_q <= '0;
            checkpoint_o      <= '0;
        end else begin
            version_head_q    <= version_head_d;
            version_tail_q    <= version_tail_d;
            num_checkpoints_q <= num_checkpoints_d;
            checkpoint_o      <= checkpoint_d;
        end
    end

endmodule

// File: rtl/free_list_fp.sv
// Checkpointed circular free list of FP physical registers feeding the FP rename table.
// The head entry falls through combinationally; commits push freed registers at the tail.
module free_list_fp
    import drac_pkg::*;
(
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          read_head_i,
    input  logic          add_free_register_i,
    input  phreg_t        free_register_i,
    input  logic          commit_advance_i,
    input  logic          do_checkpoint_i,
    input  logic          do_recover_i,
    input  logic          delete_checkpoint_i,
    input  checkpoint_ptr recover_checkpoint_i,
    input  logic          recover_commit_i,
    output phreg_t        new_register_o,
    output checkpoint_ptr checkpoint_o,
    output logic          out_of_checkpoints_o,
    output logic          empty_o
);

    phreg_t        list_q [FP_FL_DEPTH];
    fl_ptr_t       head_copy_q [NUM_CHECKPOINTS];
    fl_ptr_t       head_q, head_d, head_pop;
    fl_ptr_t       tail_q, tail_d;
    fl_ptr_t       commit_head_q, commit_head_d;
    fl_ptr_t       count;
    logic          pop, push_req, push, full;
    logic          ckpt_en;
    checkpoint_ptr ckpt_slot;

    free_list_checkpoint_ctrl u_ckpt_ctrl (
        .clk_i                (clk_i),
        .rstn_i               (rstn_i),
        .do_checkpoint_i      (do_checkpoint_i),
        .do_recover_i         (do_recover_i),
        .delete_checkpoint_i  (delete_checkpoint_i),
        .recover_checkpoint_i (recover_checkpoint_i),
        .recover_commit_i     (recover_commit_i),
        .ckpt_en_c_o          (ckpt_en),
        .ckpt_slot_c_o        (ckpt_slot),
        .checkpoint_o         (checkpoint_o),
        .out_of_checkpoints_o (out_of_checkpoints_o)
    );

    assign count          = tail_q - head_q;
    assign empty_o        = (count == '0);
    assign full           = (count == fl_ptr_t'(FP_FL_DEPTH));
    assign new_register_o = list_q[head_q[FP_FL_IDX-1:0]];

    // Recovery cycles never allocate; physical register 0 is never returned to the list
    assign pop      = read_head_i & ~empty_o & ~do_recover_i & ~recover_commit_i;
    assign push_req = add_free_register_i & (free_register_i != '0);
    assign push     = push_req & ~full;
    assign head_pop = head_q + fl_ptr_t'(pop);

    always_comb begin
        commit_head_d = commit_head_q + fl_ptr_t'(commit_advance_i);
        tail_d        = tail_q + fl_ptr_t'(push);
        head_d        = head_pop;
        if (recover_commit_i) begin
            head_d = commit_head_d;
        end else if (do_recover_i) begin
            head_d = head_copy_q[recover_checkpoint_i];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q        <= '0;
            tail_q        <= fl_ptr_t'(FP_FL_DEPTH);
            commit_head_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            commit_head_q <= commit_head_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < FP_FL_DEPTH; i++) begin
                list_q[i] <= phreg_t'(NUM_ISA_REGISTERS + i);
            end
        end else if (push) begin
            list_q[tail_q[FP_FL_IDX-1:0]] <= free_register_i;
        end
    end

    // Snapshot the post-pop head so recovery resumes right after the branch's own allocation
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < NUM_CHECKPOINTS; i++) begin
                head_copy_q[i] <= '0;
            end
        end else if (ckpt_en) begin
            head_copy_q[ckpt_slot] <= head_pop;
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk_i) disable iff (!rstn_i) !(push_req && full)
    ) else $error("free_list_fp: register freed into a full list");

    a_pointer_order: assert property (
        @(posedge clk_i) disable iff (!rstn_i)
        fl_ptr_t'(head_q - commit_head_q) <= fl_ptr_t'(tail_q - commit_head_q)
    ) else $error("free_list_fp: commit_head/head/tail out of order");

endmodule

// File: tb/tb_free_list_fp.sv
// Directed bench for free_list_fp: allocation order, empty/full wrap, checkpoints and recovery.
module tb_free_list_fp;
    import drac_pkg::*;

    logic          clk;
    logic          rstn;
    logic          read_head;
    logic          add_free;
    phreg_t        free_reg;
    logic          commit_adv;
    logic          do_ckpt;
    logic          do_rec;
    logic          del_ckpt;
    checkpoint_ptr rec_ckpt;
    logic          rec_commit;
    phreg_t        new_reg;
    checkpoint_ptr ckpt_label;
    logic          ooc;
    logic          empty;

    int checks;
    int errors;
    int exp_q[$];

    free_list_fp dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .read_head_i          (read_head),
        .add_free_register_i  (add_free),
        .free_register_i      (free_reg),
        .commit_advance_i     (commit_adv),
        .do_checkpoint_i      (do_ckpt),
        .do_recover_i         (do_rec),
        .delete_checkpoint_i  (del_ckpt),
        .recover_checkpoint_i (rec_ckpt),
        .recover_commit_i     (rec_commit),
        .new_register_o       (new_reg),
        .checkpoint_o         (ckpt_label),
        .out_of_checkpoints_o (ooc),
        .empty_o              (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        read_head  = 1'b0;
        add_free   = 1'b0;
        free_reg   = '0;
        commit_adv = 1'b0;
        do_ckpt    = 1'b0;
        do_rec     = 1'b0;
        del_ckpt   = 1'b0;
        rec_ckpt   = '0;
        rec_commit = 1'b0;
    endtask

    // One clock with the currently driven inputs, then sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_new_reg", 32'(new_reg), 32);
        chk("reset_empty", 32'(empty), 0);
        chk("reset_ckpt_label", 32'(ckpt_label), 0);
        chk("reset_ooc", 32'(ooc), 0);
        rstn = 1'b1;

        // Consecutive allocations fall through in reset order
        for (int i = 0; i < 3; i++) begin
            chk("pop_seq", 32'(new_reg), 32'(32 + i));
            read_head = 1'b1;
            tick();
        end
        chk("pop_after3", 32'(new_reg), 35);
        chk("pop_after3_empty", 32'(empty), 0);

        // Drain to empty; a read while empty must not move head
        for (int i = 3; i < 31; i++) begin
            read_head = 1'b1;
            tick();
        end
        chk("one_left_not_empty", 32'(empty), 0);
        chk("last_entry", 32'(new_reg), 63);
        read_head = 1'b1;
        tick();
        chk("drained_empty", 32'(empty), 1);
        read_head = 1'b1;
        tick();
        chk("read_while_empty", 32'(empty), 1);
        chk("read_while_empty_head", 32'(new_reg), 32);

        // Asynchronous reset mid-operation
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_new_reg", 32'(new_reg), 32);
        chk("async_reset_empty", 32'(empty), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Checkpoint at head=2, pop 5, recover label 1
        read_head = 1'b1; tick();
        read_head = 1'b1; tick();
        do_ckpt = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            read_head = 1'b1;
            tick();
        end
        chk("ckpt_label_1", 32'(ckpt_label), 1);
        chk("pre_recover_head", 32'(new_reg), 39);
        do_rec = 1'b1; rec_ckpt = 2'd1; read_head = 1'b1; tick();
        chk("recover_head", 32'(new_reg), 34);
        chk("recover_ooc", 32'(ooc), 0);

        // Two more checkpoints fill the table (1 live after recovery)
        do_ckpt = 1'b1; tick();
        do_ckpt = 1'b1; tick();
        chk("full_ckpt_ooc", 32'(ooc), 1);
        chk("full_ckpt_label", 32'(ckpt_label), 2);
        do_ckpt = 1'b1; tick();
        tick();
        chk("ckpt_ignored_label", 32'(ckpt_label), 3);
        chk("ckpt_ignored_ooc", 32'(ooc), 1);
        chk("ckpt_ignored_head", 32'(new_reg), 34);
        del_ckpt = 1'b1; tick();
        chk("delete_ooc", 32'(ooc), 0);

        // Exception flush back to commit head
        do_reset();
        read_head = 1'b1; tick();
        read_head = 1'b1; do_ckpt = 1'b1; tick();
        read_head = 1'b1; commit_adv = 1'b1; tick();
        read_head = 1'b1; commit_adv = 1'b1; tick();
        chk("pre_flush_head", 32'(new_reg), 36);
        chk("pre_flush_label", 32'(ckpt_label), 1);
        rec_commit = 1'b1; read_head = 1'b1; do_ckpt = 1'b1; tick();
        chk("flush_head", 32'(new_reg), 34);
        chk("flush_label", 32'(ckpt_label), 0);
        chk("flush_ooc", 32'(ooc), 0);
        do_ckpt = 1'b1; tick();
        do_ckpt = 1'b1; tick();
        chk("flush_two_ckpt_ooc", 32'(ooc), 0);
        do_ckpt = 1'b1; tick();
        chk("flush_three_ckpt_ooc", 32'(ooc), 1);

        // Free into an empty list; register 0 is ignored
        do_reset();
        for (int i = 0; i < 32; i++) begin
            read_head = 1'b1;
            tick();
        end
        chk("drain32_empty", 32'(empty), 1);
        add_free = 1'b1; free_reg = 6'd5; commit_adv = 1'b1; tick();
        add_free = 1'b1; free_reg = 6'd0; commit_adv = 1'b1; tick();
        chk("free5_not_empty", 32'(empty), 0);
        chk("free5_head", 32'(new_reg), 5);
        read_head = 1'b1; tick();
        chk("free0_ignored", 32'(empty), 1);

        // Three full drain/refill rounds across the pointer wrap
        do_reset();
        exp_q = {};
        for (int i = 0; i < 32; i++) exp_q.push_back(32 + i);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) begin
                chk("round_pop", 32'(new_reg), 32'(exp_q.pop_front()));
                read_head = 1'b1;
                tick();
            end
            chk("round_empty", 32'(empty), 1);
            for (int i = 0; i < 32; i++) begin
                add_free   = 1'b1;
                free_reg   = phreg_t'(1 + ((r * 32 + i) % 63));
                commit_adv = 1'b1;
                exp_q.push_back(1 + ((r * 32 + i) % 63));
                tick();
            end
            chk("round_full_not_empty", 32'(empty), 0);
            chk("round_full_head", 32'(new_reg), 32'(exp_q[0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_list_fp.md
Name: free_list_fp

Overview:
- Checkpointed circular free list of floating-point physical registers for the FP rename stage.
- Supplies a fresh physical destination to the FP rename table on every renaming allocation.
- Takes back old physical destinations released at commit.
- Keeps checkpoint labels in lock-step with the FP rename table, so branch recovery and commit-table recovery restore allocation state consistently with the rename mappings.

Parameters:
- NUM_PHYSICAL_REGISTERS, 64, total FP physical registers.
- NUM_ISA_REGISTERS, 32, architectural FP registers; physical 0..31 are mapped at reset.
- NUM_CHECKPOINTS, 4, checkpoint copies; must match the FP rename table.
- DEPTH, NUM_PHYSICAL_REGISTERS-NUM_ISA_REGISTERS (32), list capacity.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- read_head_i  in  1  allocate: pop head entry this cycle
- add_free_register_i  in  1  commit frees a register
- free_register_i  in  phreg_t  physical register being freed
- commit_advance_i  in  1  committed instruction had an FP destination; advance commit head
- do_checkpoint_i  in  1  take checkpoint after this cycle's pop
- do_recover_i  in  1  restore checkpoint recover_checkpoint_i
- delete_checkpoint_i  in  1  release oldest checkpoint
- recover_checkpoint_i  in  checkpoint_ptr  checkpoint to restore
- recover_commit_i  in  1  exception flush: head <= commit head
- new_register_o  out  phreg_t  current head entry (combinational)
- checkpoint_o  out  checkpoint_ptr  label of checkpoint taken
- out_of_checkpoints_o  out  1  num_checkpoints == NUM_CHECKPOINTS-1
- empty_o  out  1  no free registers

Behaviour:
- State:
  - list[DEPTH] of phreg_t.
  - head, tail, commit_head: $clog2(DEPTH)+1-bit pointers; the extra bit distinguishes full from empty.
  - head_copy[NUM_CHECKPOINTS].
  - version_head, version_tail: checkpoint_ptr.
  - num_checkpoints: $clog2(NUM_CHECKPOINTS)+1 bits.
- Reset (async):
  - list[i]=NUM_ISA_REGISTERS+i; head=0; commit_head=0; tail=DEPTH (full).
  - version_head=0; version_tail=0; num_checkpoints=0; head_copy[*]=0.
  - checkpoint_o=0; empty_o=0; new_register_o=32.
- Count and outputs:
  - count = tail-head, mod 2*DEPTH.
  - empty_o = (count==0).
  - new_register_o = list[head[low bits]]; zero-latency first-word-fall-through, combinational.
- Enables:
  - pop = read_head_i & ~empty_o & ~do_recover_i & ~recover_commit_i. Read while empty: no pointer move; the stage must stall on empty_o.
  - ckpt_en = do_checkpoint_i & (num_checkpoints < NUM_CHECKPOINTS-1) & ~do_recover_i & ~recover_commit_i. This must be bit-identical to the FP rename table enable.
- Push:
  - When add_free_register_i & free_register_i!=0: list[tail]<=free_register_i; tail+1.
  - Honoured in every cycle, including recover cycles; commits are older than any flush.
  - Push when count==DEPTH is a protocol error: drop it and fire an assertion.
  - Freeing phreg 0 is ignored; it stays pinned.
- Commit head: commit_advance_i → commit_head+1, in every cycle including recovery.
- Checkpoint (ckpt_en):
  - head_copy[version_head+1] <= head+pop; version_head+1.
  - num_checkpoints + ckpt_en - delete_checkpoint_i.
- Delete: version_tail + delete_checkpoint_i, in all non-recover_commit cycles.
- do_recover_i (and not recover_commit_i):
  - head <= head_copy[recover_checkpoint_i]; version_head <= recover_checkpoint_i.
  - num_checkpoints = recover - version_tail if recover >= version_tail, else NUM_CHECKPOINTS - version_tail + recover.
  - No pop and no checkpoint that cycle.
- recover_commit_i (highest priority):
  - head <= commit_head next value.
  - version_head, version_tail, num_checkpoints <= 0; checkpoint_o <= 0.
  - Push and commit advance still apply.
- checkpoint_o: registered; takes version_head's pre-update value each non-recover_commit cycle, matching the rename table label.
- Invariant: commit_head ≤ head ≤ tail (mod 2*DEPTH), covered by an assertion.
- Wrap: all pointers wrap naturally at 2*DEPTH; the index is the low bits.
- Reset mid-operation: returns immediately to the reset state, and all outstanding checkpoints are lost.

Decomposition:
- Reuse phreg_t, checkpoint_ptr, NUM_CHECKPOINTS and NUM_ISA_REGISTERS from drac_pkg.
- Add NUM_FP_PHYSICAL_REGISTERS and fl_ptr_t (head/tail pointer type) to drac_pkg.
- Add one sub-module, free_list_checkpoint_ctrl: version_head, version_tail, num_checkpoints, enables and checkpoint_o. It is shareable with the integer free list.

Test Plan:
- Reset, then pop 3 consecutive cycles → new_register_o 32, 33, 34; then 35 shown; empty_o=0.
- Pop 32 times with no frees → empty_o=1 on the 33rd cycle; read_head_i while empty leaves head unchanged.
- Checkpoint at head=2, pop 5, do_recover_i with label 1 → new_register_o=34 next cycle; num_checkpoints=1 if version_tail=0.
- 3 checkpoints → out_of_checkpoints_o=1; a 4th do_checkpoint_i is ignored (version_head stays 3); delete_checkpoint_i → flag drops.
- Pop 4 with commit_advance_i twice, then recover_commit_i → head=2; new_register_o=34; checkpoint_o=0; num_checkpoints=0.
- Pop 32 → empty; free regs 5 and 0 → count=1; new_register_o=5 (0 ignored); the tail wrap keeps full/empty correct over 3 full cycles.
